// File: rtl/algo_nr1w_repl_fwd_top_wrap.sv
// nR1W wrapper over NUMRDPRT replicated 1R1W banks: writes broadcast to every copy,
// post-reset zero sweep, optional in/out flops, same-cycle write-to-read forwarding.
module algo_nr1w_repl_fwd_top_wrap #(
  parameter int WIDTH    = 15,
  parameter int NUMADDR  = 256,
  parameter int BITADDR  = 8,
  parameter int NUMRDPRT = 2,
  parameter int T1_DELAY = 2,
  parameter int FLOPIN   = 0,
  parameter int FLOPOUT  = 0,
  parameter int RST_INIT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         ready,
  input  logic [NUMRDPRT-1:0]          read,
  input  logic [NUMRDPRT*BITADDR-1:0]  rd_adr,
  output logic [NUMRDPRT-1:0]          rd_vld,
  output logic [NUMRDPRT*WIDTH-1:0]    rd_dout,
  input  logic                         write,
  input  logic [BITADDR-1:0]           wr_adr,
  input  logic [WIDTH-1:0]             din,
  input  logic [WIDTH-1:0]             bw,
  output logic [NUMRDPRT-1:0]          t1_readB,
  output logic [NUMRDPRT*BITADDR-1:0]  t1_addrB,
  input  logic [NUMRDPRT*WIDTH-1:0]    t1_doutB,
  output logic [NUMRDPRT-1:0]          t1_writeA,
  output logic [NUMRDPRT*BITADDR-1:0]  t1_addrA,
  output logic [NUMRDPRT*WIDTH-1:0]    t1_dinA,
  output logic [NUMRDPRT*WIDTH-1:0]    t1_bwA
);

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam int LAST = T1_DELAY - 1;

  logic [NUMRDPRT-1:0]         read_s;
  logic [NUMRDPRT*BITADDR-1:0] rd_adr_s;
  logic                        write_s;
  logic [BITADDR-1:0]          wr_adr_s;
  logic [WIDTH-1:0]            din_s;
  logic [WIDTH-1:0]            bw_s;

  generate
    if (FLOPIN != 0) begin : g_flopin
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          read_s   <= '0;
          rd_adr_s <= '0;
          write_s  <= 1'b0;
          wr_adr_s <= '0;
          din_s    <= '0;
          bw_s     <= '0;
        end else begin
          read_s   <= read;
          rd_adr_s <= rd_adr;
          write_s  <= write;
          wr_adr_s <= wr_adr;
          din_s    <= din;
          bw_s     <= bw;
        end
      end
    end else begin : g_noflopin
      always_comb begin
        read_s   = read;
        rd_adr_s = rd_adr;
        write_s  = write;
        wr_adr_s = wr_adr;
        din_s    = din;
        bw_s     = bw;
      end
    end
  endgenerate

  logic [0:0]         state;
  logic [BITADDR-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= (RST_INIT != 0) ? INIT : RUN;
      cnt   <= '0;
    end else if (state == INIT) begin
      cnt <= cnt + BITADDR'(1);
      if (cnt == BITADDR'(NUMADDR - 1))
        state <= RUN;
    end
  end

  // Macro strobes are gated by rst so every t1_* output reads zero while held in reset.
  logic run;
  logic sweep;
  logic wr_ok;
  assign ready = (state == RUN);
  assign run   = (state == RUN) && !rst;
  assign sweep = (state == INIT) && !rst;
  assign wr_ok = 32'(wr_adr_s) < NUMADDR;

  always_comb begin
    t1_writeA = '0;
    t1_addrA  = '0;
    t1_dinA   = '0;
    t1_bwA    = '0;
    for (int unsigned i = 0; i < NUMRDPRT; i++) begin
      if (sweep) begin
        t1_writeA[i]                  = 1'b1;
        t1_addrA[i*BITADDR +: BITADDR] = cnt;
        t1_bwA[i*WIDTH +: WIDTH]       = '1;
      end else if (run) begin
        t1_writeA[i]                  = write_s && wr_ok;
        t1_addrA[i*BITADDR +: BITADDR] = wr_adr_s;
        t1_dinA[i*WIDTH +: WIDTH]      = din_s;
        t1_bwA[i*WIDTH +: WIDTH]       = bw_s;
      end
    end
  end

  assign t1_readB = read_s & {NUMRDPRT{run}};
  assign t1_addrB = run ? rd_adr_s : '0;

  logic [NUMRDPRT-1:0] hit;
  always_comb begin
    hit = '0;
    for (int unsigned p = 0; p < NUMRDPRT; p++)
      hit[p] = run && write_s && read_s[p] && (rd_adr_s[p*BITADDR +: BITADDR] == wr_adr_s);
  end

  // Write data/mask travel once for all ports; each port keeps its own hit flag.
  logic [NUMRDPRT-1:0] vld_p [T1_DELAY];
  logic [NUMRDPRT-1:0] hit_p [T1_DELAY];
  logic [WIDTH-1:0]    din_p [T1_DELAY];
  logic [WIDTH-1:0]    bw_p  [T1_DELAY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < T1_DELAY; k++) begin
        vld_p[k] <= '0;
        hit_p[k] <= '0;
        din_p[k] <= '0;
        bw_p[k]  <= '0;
      end
    end else begin
      vld_p[0] <= t1_readB;
      hit_p[0] <= hit;
      din_p[0] <= din_s;
      bw_p[0]  <= bw_s;
      for (int unsigned k = 1; k < T1_DELAY; k++) begin
        vld_p[k] <= vld_p[k-1];
        hit_p[k] <= hit_p[k-1];
        din_p[k] <= din_p[k-1];
        bw_p[k]  <= bw_p[k-1];
      end
    end
  end

  logic [NUMRDPRT-1:0]       vld_ret;
  logic [NUMRDPRT*WIDTH-1:0] merged;
  logic [NUMRDPRT*WIDTH-1:0] hold;
  logic [NUMRDPRT*WIDTH-1:0] dout_ret;

  assign vld_ret = vld_p[LAST];

  always_comb begin
    merged   = t1_doutB;
    dout_ret = hold;
    for (int unsigned p = 0; p < NUMRDPRT; p++) begin
      if (hit_p[LAST][p])
        merged[p*WIDTH +: WIDTH] = (t1_doutB[p*WIDTH +: WIDTH] & ~bw_p[LAST]) |
                                   (din_p[LAST] & bw_p[LAST]);
      if (vld_ret[p])
        dout_ret[p*WIDTH +: WIDTH] = merged[p*WIDTH +: WIDTH];
    end
  end

  // Last delivered word per port, so rd_dout holds between valid cycles even unflopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else begin
      for (int unsigned p = 0; p < NUMRDPRT; p++)
        if (vld_ret[p])
          hold[p*WIDTH +: WIDTH] <= merged[p*WIDTH +: WIDTH];
    end
  end

  generate
    if (FLOPOUT == 0) begin : g_noflopout
      assign rd_vld  = vld_ret;
      assign rd_dout = dout_ret;
    end else begin : g_flopout
      logic [NUMRDPRT-1:0]       vld_o  [FLOPOUT];
      logic [NUMRDPRT*WIDTH-1:0] dout_o [FLOPOUT];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned k = 0; k < FLOPOUT; k++) begin
            vld_o[k]  <= '0;
            dout_o[k] <= '0;
          end
        end else begin
          vld_o[0]  <= vld_ret;
          dout_o[0] <= dout_ret;
          for (int unsigned k = 1; k < FLOPOUT; k++) begin
            vld_o[k]  <= vld_o[k-1];
            dout_o[k] <= dout_o[k-1];
          end
        end
      end
      assign rd_vld  = vld_o[FLOPOUT-1];
      assign rd_dout = dout_o[FLOPOUT-1];
    end
  endgenerate

endmodule

// File: tb/tb_algo_nr1w_repl_fwd_top_wrap.sv
// Bench: two wrappers (unflopped, and FLOPIN=1/FLOPOUT=2) over behavioural read-first
// macros, checked every cycle against a logical-memory model with per-port due slots.
module tb_algo_nr1w_repl_fwd_top_wrap;
  localparam int W  = 15;
  localparam int NA = 256;
  localparam int BA = 8;
  localparam int NP = 2;
  localparam int TD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0]    read;
  logic [NP*BA-1:0] rd_adr;
  logic             write;
  logic [BA-1:0]    wr_adr;
  logic [W-1:0]     din, bw;

  logic             ready0, ready1;
  logic [NP-1:0]    rd_vld0, rd_vld1, t1_readB0, t1_readB1, t1_writeA0, t1_writeA1;
  logic [NP*W-1:0]  rd_dout0, rd_dout1, t1_doutB0, t1_doutB1;
  logic [NP*W-1:0]  t1_dinA0, t1_dinA1, t1_bwA0, t1_bwA1;
  logic [NP*BA-1:0] t1_addrB0, t1_addrB1, t1_addrA0, t1_addrA1;

  algo_nr1w_repl_fwd_top_wrap #(.WIDTH(W), .NUMADDR(NA), .BITADDR(BA), .NUMRDPRT(NP),
    .T1_DELAY(TD), .FLOPIN(0), .FLOPOUT(0), .RST_INIT(1)) dut0 (
    .clk(clk), .rst(rst), .ready(ready0), .read(read), .rd_adr(rd_adr), .rd_vld(rd_vld0),
    .rd_dout(rd_dout0), .write(write), .wr_adr(wr_adr), .din(din), .bw(bw),
    .t1_readB(t1_readB0), .t1_addrB(t1_addrB0), .t1_doutB(t1_doutB0), .t1_writeA(t1_writeA0),
    .t1_addrA(t1_addrA0), .t1_dinA(t1_dinA0), .t1_bwA(t1_bwA0));

  algo_nr1w_repl_fwd_top_wrap #(.WIDTH(W), .NUMADDR(NA), .BITADDR(BA), .NUMRDPRT(NP),
    .T1_DELAY(TD), .FLOPIN(1), .FLOPOUT(2), .RST_INIT(1)) dut1 (
    .clk(clk), .rst(rst), .ready(ready1), .read(read), .rd_adr(rd_adr), .rd_vld(rd_vld1),
    .rd_dout(rd_dout1), .write(write), .wr_adr(wr_adr), .din(din), .bw(bw),
    .t1_readB(t1_readB1), .t1_addrB(t1_addrB1), .t1_doutB(t1_doutB1), .t1_writeA(t1_writeA1),
    .t1_addrA(t1_addrA1), .t1_dinA(t1_dinA1), .t1_bwA(t1_bwA1));

  logic [NP-1:0]    e_rd [2], e_wr [2], a_vld [2];
  logic [NP*BA-1:0] e_ab [2], e_aa [2];
  logic [NP*W-1:0]  e_din [2], e_bw [2], a_dout [2];
  logic             a_rdy [2];
  assign e_rd[0] = t1_readB0;  assign e_rd[1] = t1_readB1;
  assign e_wr[0] = t1_writeA0; assign e_wr[1] = t1_writeA1;
  assign e_ab[0] = t1_addrB0;  assign e_ab[1] = t1_addrB1;
  assign e_aa[0] = t1_addrA0;  assign e_aa[1] = t1_addrA1;
  assign e_din[0] = t1_dinA0;  assign e_din[1] = t1_dinA1;
  assign e_bw[0] = t1_bwA0;    assign e_bw[1] = t1_bwA1;
  assign a_vld[0] = rd_vld0;   assign a_vld[1] = rd_vld1;
  assign a_dout[0] = rd_dout0; assign a_dout[1] = rd_dout1;
  assign a_rdy[0] = ready0;    assign a_rdy[1] = ready1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, d, b);
    return (old & ~b) | (d & b);
  endfunction

  // Read-first macro copies, preloaded with nonzero junk so the zero sweep is observable.
  logic [W-1:0] mem  [2][NP][NA];
  logic [W-1:0] pipe [2][NP][TD];
  assign t1_doutB0 = {pipe[0][1][TD-1], pipe[0][0][TD-1]};
  assign t1_doutB1 = {pipe[1][1][TD-1], pipe[1][0][TD-1]};

  initial begin
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NP; c++) begin
        for (int a = 0; a < NA; a++) mem[k][c][a] = W'(a * 97 + c + 1) | 15'h4000;
        for (int j = 0; j < TD; j++) pipe[k][c][j] = '0;
      end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NP; c++) begin
        pipe[k][c][0] <= e_rd[k][c] ? mem[k][c][e_ab[k][c*BA +: BA]] : 15'h1357;
        for (int j = 1; j < TD; j++) pipe[k][c][j] <= pipe[k][c][j-1];
        if (e_wr[k][c])
          mem[k][c][e_aa[k][c*BA +: BA]] = merge(mem[k][c][e_aa[k][c*BA +: BA]],
                                                 e_din[k][c*W +: W], e_bw[k][c*W +: W]);
      end
  end

  // Reference: one logical memory per instance; each accepted read is answered
  // (write-before-read) and scheduled for the cycle FLOPIN+T1_DELAY+FLOPOUT later.
  int cyc = 0;
  int since = 0;
  logic [W-1:0] ref_mem [2][NA];
  bit           ev [2][NP][32];
  logic [W-1:0] ed [2][NP][32];
  int fin [2] = '{0, 1};
  int lat [2] = '{2, 5};

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      since = 0;
      for (int k = 0; k < 2; k++) begin
        for (int a = 0; a < NA; a++) ref_mem[k][a] = '0;
        for (int p = 0; p < NP; p++)
          for (int s = 0; s < 32; s++) ev[k][p][s] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (since + fin[k] >= NA) begin
          for (int p = 0; p < NP; p++) begin
            if (read[p]) begin
              logic [BA-1:0] a;
              logic [W-1:0]  v;
              a = rd_adr[p*BA +: BA];
              v = ref_mem[k][a];
              if (write && wr_adr == a) v = merge(v, din, bw);
              ev[k][p][(cyc + lat[k] - 1) % 32] = 1'b1;
              ed[k][p][(cyc + lat[k] - 1) % 32] = v;
            end
          end
          if (write) ref_mem[k][wr_adr] = merge(ref_mem[k][wr_adr], din, bw);
        end
      end
      since++;
    end
  end

  logic [W-1:0] last [2][NP];
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [7:0] s8;
      s8 = since[7:0];
      chk("ready", 64'(a_rdy[k]), 64'(!rst && since >= NA));
      if (rst) begin
        chk("t1_in_reset", 64'({e_rd[k], e_wr[k], e_ab[k], e_aa[k]} == '0 && e_din[k] == '0
                               && e_bw[k] == '0), 64'd1);
      end else if (since < NA) begin
        chk("sweep_we", 64'(e_wr[k]), 64'(2'b11));
        chk("sweep_adr", 64'(e_aa[k]), 64'({s8, s8}));
        chk("sweep_data", 64'({e_din[k], e_bw[k]}), 64'({30'h0, 30'h3FFFFFFF}));
        chk("sweep_no_read", 64'(e_rd[k]), 64'd0);
      end
      for (int p = 0; p < NP; p++) begin
        bit v;
        v = !rst && ev[k][p][cyc % 32];
        if (rst) last[k][p] = '0;
        if (v) begin
          last[k][p] = ed[k][p][cyc % 32];
          ev[k][p][cyc % 32] = 1'b0;
        end
        chk("rd_vld", 64'(a_vld[k][p]), 64'(v));
        chk("rd_dout", 64'(a_dout[k][p*W +: W]), 64'(last[k][p]));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic idle;
    read = '0; rd_adr = '0; write = 1'b0; wr_adr = '0; din = '0; bw = '0;
  endtask

  task automatic req(input logic [1:0] rd, input logic [7:0] a0, a1, input logic w,
                     input logic [7:0] wa, input logic [W-1:0] d, b);
    read = rd; rd_adr = {a1, a0}; write = w; wr_adr = wa; din = d; bw = b;
    tick;
    idle;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int c0, c1;
    idle;
    rst = 1'b1;
    repeat (3) tick;
    chk("lit_rst_ready", 64'(ready0), 64'd0);
    chk("lit_rst_vld", 64'(rd_vld0), 64'd0);
    chk("lit_rst_we", 64'(t1_writeA0), 64'd0);
    rst = 1'b0;
    repeat (100) tick;
    chk("lit_sweep_at_100", 64'(t1_addrA0[7:0]), 64'd100);
    rst = 1'b1;
    tick;
    chk("lit_midrst_we", 64'(t1_writeA0), 64'd0);
    chk("lit_midrst_ready", 64'(ready0), 64'd0);
    tick;
    rst = 1'b0;
    n = 0;
    while (!ready0 && n < 400) begin
      if (n == 50) req(2'b11, 8'd33, 8'd33, 1'b1, 8'd33, 15'h5555, 15'h7FFF);
      else tick;
      n++;
    end
    chk("lit_ready_latency", 64'(n), 64'd256);

    req(2'b11, 8'd17, 8'd17, 1'b0, 8'd0, 15'h0, 15'h0);
    tick;
    chk("lit_adr17_vld", 64'(rd_vld0), 64'(2'b11));
    chk("lit_adr17_dout", 64'(rd_dout0), 64'd0);
    repeat (3) tick;
    chk("lit_adr17_vld_flopped", 64'(rd_vld1), 64'(2'b11));

    req(2'b00, 8'd0, 8'd0, 1'b1, 8'd5, 15'h1234, 15'h7FFF);
    req(2'b11, 8'd5, 8'd5, 1'b0, 8'd0, 15'h0, 15'h0);
    tick;
    chk("lit_adr5_p0", 64'(rd_dout0[14:0]), 64'h1234);
    chk("lit_adr5_p1", 64'(rd_dout0[29:15]), 64'h1234);

    req(2'b00, 8'd0, 8'd0, 1'b1, 8'd9, 15'h7FFF, 15'h7FFF);
    req(2'b00, 8'd0, 8'd0, 1'b1, 8'd8, 15'h0ABC, 15'h7FFF);
    req(2'b11, 8'd9, 8'd8, 1'b1, 8'd9, 15'h0000, 15'h00FF);
    tick;
    chk("lit_fwd_p0", 64'(rd_dout0[14:0]), 64'h7F00);
    chk("lit_fwd_p1", 64'(rd_dout0[29:15]), 64'h0ABC);
    tick;
    chk("lit_hold_vld", 64'(rd_vld0), 64'd0);
    chk("lit_hold_p0", 64'(rd_dout0[14:0]), 64'h7F00);
    repeat (2) tick;
    chk("lit_fwd_flopped_p0", 64'(rd_dout1[14:0]), 64'h7F00);
    chk("lit_fwd_flopped_p1", 64'(rd_dout1[29:15]), 64'h0ABC);
    req(2'b01, 8'd9, 8'd0, 1'b0, 8'd0, 15'h0, 15'h0);
    tick;
    chk("lit_adr9_after", 64'(rd_dout0[14:0]), 64'h7F00);

    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 28; i++) begin
      if (i < 20) begin
        read = 2'b11;
        rd_adr = {8'(i + 3), 8'(i)};
        write = (i % 3 != 2);
        wr_adr = (i % 3 == 0) ? 8'(i + 1) : 8'(i + 3);
        din = 15'(i * 37 + 5);
        bw = (i % 2 == 0) ? 15'h7FFF : 15'h0F0F;
      end else begin
        idle;
      end
      tick;
      if (rd_vld0 == 2'b11) c0++;
      if (rd_vld1 == 2'b11) c1++;
    end
    chk("lit_stream_vld0", 64'(c0), 64'd20);
    chk("lit_stream_vld1", 64'(c1), 64'd20);

    req(2'b11, 8'd33, 8'd33, 1'b0, 8'd0, 15'h0, 15'h0);
    tick;
    chk("lit_init_write_dropped", 64'(rd_dout0), 64'd0);
    repeat (8) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
